sync_fifo_param: RTL

- Parametrised single-clock FIFO. Next-generation replacement for the fixed 8-bit / 4-bit-address FIFO.
- Uses all 2**ADDR_WIDTH entries and accepts push and pop in the same cycle.
- Adds occupancy count, programmable almost-full/almost-empty flags and synchronous flush.
- Sits between a producer and a consumer on the same clock. Used as the DUT for the next go2uvm FIFO bench.

---
 rtl/sync_fifo_param.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty flags and flush.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output instead of a registered read.
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  push_err_on_full,
  output logic                  pop_err_on_empty
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t AFULL_T  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_T = ptr_t'(AEMPTY_THRESH);

  generate
    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("sync_fifo_param: AFULL_THRESH must lie in 0..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
      $error("sync_fifo_param: AEMPTY_THRESH must lie in 0..DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t w_ptr_q, w_ptr_d;
  ptr_t r_ptr_q, r_ptr_d;
  ptr_t count_q, count_d;
  logic push_err_q, push_err_d;
  logic pop_err_q, pop_err_d;

  logic                  full_w, empty_w;
  logic                  push_ok, pop_ok;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;

  assign w_addr = w_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr = r_ptr_q[ADDR_WIDTH-1:0];

  // Pointer MSB is a wrap bit: equal addresses mean full when laps differ, empty when they match.
  assign full_w  = (w_addr == r_addr) && (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]);
  assign empty_w = (w_ptr_q == r_ptr_q);

  assign pop_ok  = pop & ~empty_w;
  assign push_ok = push & (~full_w | pop_ok);

  always_comb begin
    w_ptr_d    = w_ptr_q;
    r_ptr_d    = r_ptr_q;
    count_d    = count_q + ptr_t'(push_ok) - ptr_t'(pop_ok);
    push_err_d = push & full_w & ~pop_ok;
    pop_err_d  = pop & empty_w;
    if (push_ok) begin
      w_ptr_d = w_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      r_ptr_d = r_ptr_q + PTR_ONE;
    end
    if (flush) begin
      w_ptr_d    = '0;
      r_ptr_d    = '0;
      count_d    = '0;
      push_err_d = 1'b0;
      pop_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      count_q    <= '0;
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
    end else begin
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      count_q    <= count_d;
      push_err_q <= push_err_d;
      pop_err_q  <= pop_err_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[w_addr] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty_w ? '0 : mem_q[r_addr];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  // Read-before-write: a simultaneous push into the slot being popped returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (pop_ok && !flush) begin
      dout_q <= mem_q[r_addr];
    end
  end

  assign data_out = dout_q;
`endif

  assign full             = full_w;
  assign empty            = empty_w;
  assign almost_full      = (count_q >= AFULL_T);
  assign almost_empty     = (count_q <= AEMPTY_T);
  assign count            = count_q;
  assign push_err_on_full = push_err_q;
  assign pop_err_on_empty = pop_err_q;

endmodule
